regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001: The block SHALL have one clock, CLKb; all state SHALL update on its falling edge.
REQ-002: The block SHALL have one reset, RSTb: asynchronous, active-low.
REQ-003: The block SHALL provide these ports (name, direction, width, meaning):
- CLKb  in  1  clock, falling-edge active
- RSTb  in  1  async active-low reset
- INSTR  in  10  instruction or immediate beat
- IVALID  in  1  INSTR holds a valid beat
- IREADY  out  1  block accepts a beat this cycle
- ENW  out  1  register-file write enable
- WRA  out  2  register-file write address
- ENR0  out  1  read port 0 enable
- RDA0  out  2  read port 0 address
- ENR1  out  1  read port 1 enable
- RDA1  out  2  read port 1 address
- ALU_OP  out  2  00 add, 01 sub, 10 xor
- LD_A  out  1  latch Q0 into ALU operand A
- LD_G  out  1  latch ALU result into G
- SEL_D  out  2  D-bus source: 00 IMM, 01 Q1, 10 G
- IMM  out  10  latched immediate
- DONE  out  1  one-cycle pulse, final cycle of instruction
- ERR  out  1  one-cycle pulse, illegal opcode

Function
REQ-004: Instruction fields SHALL be: opcode INSTR[9:6], Rx INSTR[5:4], Ry INSTR[3:2]; INSTR[1:0] are ignored.
REQ-005: Opcodes SHALL be: 0000 LOAD (Rx <= next beat), 0001 COPY (Rx <= Ry), 0010 ADD, 0011 SUB, 0100 XOR (Rx <= Rx op Ry). All other opcodes are illegal.
REQ-006: A beat SHALL transfer only on a falling edge with IVALID=1 and IREADY=1; IVALID SHALL be ignored while IREADY=0.
REQ-007: IREADY SHALL be 1 only in states IDLE and LDIMM.
REQ-008: States SHALL be IDLE, LDIMM, WIMM, COPY, OPRD, EXEC, WB. All outputs SHALL be Moore-decoded from state and the latched Rx, Ry, opcode and IMM.
REQ-009: IDLE transitions on a transfer:
- LOAD -> LDIMM
- COPY -> COPY
- ADD/SUB/XOR -> OPRD
- illegal -> ERRS
REQ-010: ERRS SHALL be a one-cycle state with ERR=1 and all enables 0, returning to IDLE. ERRS is added to the state list for this purpose.
REQ-011: LDIMM SHALL wait indefinitely. When a beat transfers, INSTR[9:0] is latched into IMM and the state moves to WIMM.
REQ-012: WIMM SHALL drive ENW=1, WRA=Rx, SEL_D=00 and DONE=1 for one cycle, then go to IDLE.
REQ-013: COPY SHALL drive ENR1=1, RDA1=Ry, ENW=1, WRA=Rx, SEL_D=01 and DONE=1 for one cycle, then go to IDLE.
REQ-014: OPRD SHALL drive ENR0=1, RDA0=Rx, LD_A=1 for one cycle, then go to EXEC.
REQ-015: EXEC SHALL drive ENR1=1, RDA1=Ry, ALU_OP per opcode (ADD 00, SUB 01, XOR 10) and LD_G=1 for one cycle, then go to WB.
REQ-016: WB SHALL drive ENW=1, WRA=Rx, SEL_D=10 and DONE=1 for one cycle, then go to IDLE.
REQ-017: Latency, counted in cycles after the accepting edge: COPY 1; ALU ops 3; LOAD 1 after the immediate beat.
REQ-018: Outputs not named for a state SHALL be 0. IMM SHALL hold its value until the next LOAD immediate.
REQ-019: ENW SHALL be asserted in at most one cycle per instruction and never in IDLE, LDIMM, OPRD, EXEC or ERRS.
REQ-020: Rx equal to Ry SHALL be legal and need no special handling; e.g. ADD R1,R1 doubles R1.
REQ-021: Back-to-back instructions SHALL be allowed. IDLE re-accepts on the first falling edge after DONE.

Reset
REQ-022: While RSTb=0, the state SHALL be IDLE and every output SHALL be 0 except IREADY=1. IMM, Rx, Ry and opcode SHALL be 0.
REQ-023: Reset asserted mid-instruction SHALL deassert ENW immediately, asynchronously. The instruction SHALL be abandoned with no DONE pulse.
REQ-024: After RSTb rises, the first transfer SHALL occur no earlier than the next falling edge.

Verification
REQ-025: LOAD with beats 0000_10_00_00, then 1010101010 -> one WIMM cycle with ENW=1, WRA=10, SEL_D=00, IMM=1010101010, DONE=1; IREADY=1 throughout LDIMM.
REQ-026: ADD R3,R1 (0010_11_01_00) -> in order: OPRD (ENR0=1, RDA0=11, LD_A=1); EXEC (ENR1=1, RDA1=01, ALU_OP=00, LD_G=1); WB (ENW=1, WRA=11, SEL_D=10, DONE=1). IREADY=0 for those 3 cycles.
REQ-027: COPY R0<=R2 (0001_00_10_00), followed back-to-back by SUB R0,R0 -> COPY cycle with ENW=1, WRA=00, RDA1=10, SEL_D=01. The SUB is accepted at the next edge, with ALU_OP=01 in its EXEC cycle.
REQ-028: Opcode 1111 -> ERR=1 for one cycle, ENW=0, DONE=0, return to IDLE; a following legal instruction executes normally.
REQ-029: RSTb pulled low during EXEC of XOR -> all enables 0 immediately, no WB, no DONE. After release, IREADY=1 and a COPY completes in 1 cycle.
REQ-030: IVALID=1 held during OPRD, EXEC and WB with a changing INSTR -> no transfer occurs; only the value present at the first IDLE edge is accepted.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Micro-sequencer for a 4-entry register file: decodes 10-bit instruction beats
// into per-cycle read/write/ALU control strobes, all updated on the falling clock edge.
module regfile_sequencer (
    input  logic       CLKb,
    input  logic       RSTb,
    input  logic [9:0] INSTR,
    input  logic       IVALID,
    output logic       IREADY,
    output logic       ENW,
    output logic [1:0] WRA,
    output logic       ENR0,
    output logic [1:0] RDA0,
    output logic       ENR1,
    output logic [1:0] RDA1,
    output logic [1:0] ALU_OP,
    output logic       LD_A,
    output logic       LD_G,
    output logic [1:0] SEL_D,
    output logic [9:0] IMM,
    output logic       DONE,
    output logic       ERR
);

    localparam int unsigned IW  = 10;
    localparam int unsigned AW  = 2;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_LOAD = 4'b0000;
    localparam logic [OPW-1:0] OP_COPY = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0011;
    localparam logic [OPW-1:0] OP_XOR  = 4'b0100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;

    localparam logic [1:0] SEL_IMM = 2'b00;
    localparam logic [1:0] SEL_Q1  = 2'b01;
    localparam logic [1:0] SEL_G   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDIMM,
        S_WIMM,
        S_COPY,
        S_OPRD,
        S_EXEC,
        S_WB,
        S_ERRS
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [OPW-1:0]  r_op,    w_op_nxt;
    logic [AW-1:0]   r_rx,    w_rx_nxt;
    logic [AW-1:0]   r_ry,    w_ry_nxt;
    logic [IW-1:0]   r_imm,   w_imm_nxt;

    logic            r_iready, w_iready_nxt;
    logic            r_enw,    w_enw_nxt;
    logic [AW-1:0]   r_wra,    w_wra_nxt;
    logic            r_enr0,   w_enr0_nxt;
    logic [AW-1:0]   r_rda0,   w_rda0_nxt;
    logic            r_enr1,   w_enr1_nxt;
    logic [AW-1:0]   r_rda1,   w_rda1_nxt;
    logic [1:0]      r_alu_op, w_alu_op_nxt;
    logic            r_ld_a,   w_ld_a_nxt;
    logic            r_ld_g,   w_ld_g_nxt;
    logic [1:0]      r_sel_d,  w_sel_d_nxt;
    logic            r_done,   w_done_nxt;
    logic            r_err,    w_err_nxt;

    logic            w_xfer;

    assign w_xfer = IVALID & r_iready;

    // Next state and instruction-field capture.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_rx_nxt    = r_rx;
        w_ry_nxt    = r_ry;
        w_imm_nxt   = r_imm;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_op_nxt = INSTR[9:6];
                    w_rx_nxt = INSTR[5:4];
                    w_ry_nxt = INSTR[3:2];
                    case (INSTR[9:6])
                        OP_LOAD:                 w_state_nxt = S_LDIMM;
                        OP_COPY:                 w_state_nxt = S_COPY;
                        OP_ADD, OP_SUB, OP_XOR:  w_state_nxt = S_OPRD;
                        default:                 w_state_nxt = S_ERRS;
                    endcase
                end
            end
            S_LDIMM: begin
                if (w_xfer) begin
                    w_imm_nxt   = INSTR;
                    w_state_nxt = S_WIMM;
                end
            end
            S_OPRD:  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WB;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode of the upcoming state, so the strobes leave flops.
    always_comb begin
        w_iready_nxt = 1'b0;
        w_enw_nxt    = 1'b0;
        w_wra_nxt    = '0;
        w_enr0_nxt   = 1'b0;
        w_rda0_nxt   = '0;
        w_enr1_nxt   = 1'b0;
        w_rda1_nxt   = '0;
        w_alu_op_nxt = '0;
        w_ld_a_nxt   = 1'b0;
        w_ld_g_nxt   = 1'b0;
        w_sel_d_nxt  = '0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (w_state_nxt)
            S_IDLE, S_LDIMM: w_iready_nxt = 1'b1;
            S_WIMM: begin
                w_enw_nxt   = 1'b1;
                w_wra_nxt   = w_rx_nxt;
                w_sel_d_nxt = SEL_IMM;
                w_done_nxt  = 1'b1;
            end
            S_COPY: begin
                w_enr1_nxt  = 1'b1;
                w_rda1_nxt  = w_ry_nxt;
                w_enw_nxt   = 1'b1;
                w_wra_nxt   = w_rx_nxt;
                w_sel_d_nxt = SEL_Q1;
                w_done_nxt  = 1'b1;
            end
            S_OPRD: begin
                w_enr0_nxt = 1'b1;
                w_rda0_nxt = w_rx_nxt;
                w_ld_a_nxt = 1'b1;
            end
            S_EXEC: begin
                w_enr1_nxt = 1'b1;
                w_rda1_nxt = w_ry_nxt;
                w_ld_g_nxt = 1'b1;
                case (w_op_nxt)
                    OP_SUB:  w_alu_op_nxt = ALU_SUB;
                    OP_XOR:  w_alu_op_nxt = ALU_XOR;
                    default: w_alu_op_nxt = ALU_ADD;
                endcase
            end
            S_WB: begin
                w_enw_nxt   = 1'b1;
                w_wra_nxt   = w_rx_nxt;
                w_sel_d_nxt = SEL_G;
                w_done_nxt  = 1'b1;
            end
            S_ERRS:  w_err_nxt = 1'b1;
            default: w_iready_nxt = 1'b0;
        endcase
    end

    // Reset clears every strobe at once, abandoning any instruction in flight.
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rx     <= '0;
            r_ry     <= '0;
            r_imm    <= '0;
            r_iready <= 1'b1;
            r_enw    <= 1'b0;
            r_wra    <= '0;
            r_enr0   <= 1'b0;
            r_rda0   <= '0;
            r_enr1   <= 1'b0;
            r_rda1   <= '0;
            r_alu_op <= '0;
            r_ld_a   <= 1'b0;
            r_ld_g   <= 1'b0;
            r_sel_d  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_rx     <= w_rx_nxt;
            r_ry     <= w_ry_nxt;
            r_imm    <= w_imm_nxt;
            r_iready <= w_iready_nxt;
            r_enw    <= w_enw_nxt;
            r_wra    <= w_wra_nxt;
            r_enr0   <= w_enr0_nxt;
            r_rda0   <= w_rda0_nxt;
            r_enr1   <= w_enr1_nxt;
            r_rda1   <= w_rda1_nxt;
            r_alu_op <= w_alu_op_nxt;
            r_ld_a   <= w_ld_a_nxt;
            r_ld_g   <= w_ld_g_nxt;
            r_sel_d  <= w_sel_d_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign IREADY = r_iready;
    assign ENW    = r_enw;
    assign WRA    = r_wra;
    assign ENR0   = r_enr0;
    assign RDA0   = r_rda0;
    assign ENR1   = r_enr1;
    assign RDA1   = r_rda1;
    assign ALU_OP = r_alu_op;
    assign LD_A   = r_ld_a;
    assign LD_G   = r_ld_g;
    assign SEL_D  = r_sel_d;
    assign IMM    = r_imm;
    assign DONE   = r_done;
    assign ERR    = r_err;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized bench for regfile_sequencer: a per-instruction reference model queues
// the expected control beats; a monitor compares every active DUT cycle against them.
module tb_regfile_sequencer;

    logic       CLKb;
    logic       RSTb;
    logic [9:0] INSTR;
    logic       IVALID;
    logic       IREADY, ENW, ENR0, ENR1, LD_A, LD_G, DONE, ERR;
    logic [1:0] WRA, RDA0, RDA1, ALU_OP, SEL_D;
    logic [9:0] IMM;

    regfile_sequencer dut (
        .CLKb(CLKb), .RSTb(RSTb), .INSTR(INSTR), .IVALID(IVALID), .IREADY(IREADY),
        .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
        .ALU_OP(ALU_OP), .LD_A(LD_A), .LD_G(LD_G), .SEL_D(SEL_D), .IMM(IMM),
        .DONE(DONE), .ERR(ERR)
    );

    typedef struct {
        int          cyc;
        logic [27:0] v;
    } rec_t;

    rec_t        sb[$];
    logic [9:0]  prog[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ready_at = 0;
    logic        pending_load = 1'b0;
    logic [1:0]  m_load_rx = 2'd0;
    logic [9:0]  m_imm = 10'd0;
    logic [27:0] act_vec;

    assign act_vec = {ENW, WRA, ENR0, RDA0, ENR1, RDA1, ALU_OP, LD_A, LD_G, SEL_D,
                      IMM, DONE, ERR, IREADY};

    initial CLKb = 1'b1;
    always #5 CLKb = ~CLKb;

    always @(negedge CLKb) cyc <= cyc + 1;

    function automatic logic [27:0] mk(
        input logic enw, input logic [1:0] wra, input logic enr0, input logic [1:0] rda0,
        input logic enr1, input logic [1:0] rda1, input logic [1:0] alu, input logic lda,
        input logic ldg, input logic [1:0] seld, input logic [9:0] imm, input logic done,
        input logic err, input logic ird);
        return {enw, wra, enr0, rda0, enr1, rda1, alu, lda, ldg, seld, imm, done, err, ird};
    endfunction

    task automatic push(input int c, input logic [27:0] v);
        rec_t r;
        r.cyc = c;
        r.v   = v;
        sb.push_back(r);
    endtask

    // Expected response of one accepted beat whose transfer edge is numbered a.
    task automatic model_accept(input logic [9:0] beat, input int a);
        int op;
        logic [1:0] rx, ry;
        op = int'(beat[9:6]);
        rx = beat[5:4];
        ry = beat[3:2];
        if (pending_load) begin
            m_imm        = beat;
            pending_load = 1'b0;
            push(a, mk(1'b1, m_load_rx, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0,
                       m_imm, 1'b1, 1'b0, 1'b0));
            ready_at = a + 1;
        end else if (op == 0) begin
            pending_load = 1'b1;
            m_load_rx    = rx;
            ready_at     = a;
        end else if (op == 1) begin
            push(a, mk(1'b1, rx, 1'b0, 2'd0, 1'b1, ry, 2'd0, 1'b0, 1'b0, 2'd1,
                       m_imm, 1'b1, 1'b0, 1'b0));
            ready_at = a + 1;
        end else if (op >= 2 && op <= 4) begin
            push(a,     mk(1'b0, 2'd0, 1'b1, rx, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0,
                           m_imm, 1'b0, 1'b0, 1'b0));
            push(a + 1, mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, ry, 2'(op - 2), 1'b0, 1'b1, 2'd0,
                           m_imm, 1'b0, 1'b0, 1'b0));
            push(a + 2, mk(1'b1, rx, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd2,
                           m_imm, 1'b1, 1'b0, 1'b0));
            ready_at = a + 3;
        end else begin
            push(a, mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0,
                       m_imm, 1'b0, 1'b1, 1'b0));
            ready_at = a + 1;
        end
    endtask

    function automatic logic [9:0] rand_instr();
        logic [3:0] op;
        op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
        return {op, 6'($urandom)};
    endfunction

    // Issue n beats; while the model says busy, drive junk with random IVALID.
    task automatic run_beats(input int n);
        int issued = 0;
        int guard  = 0;
        logic exp_rdy;
        logic [9:0] beat;
        while (issued < n && guard < 5000) begin
            @(posedge CLKb);
            guard++;
            exp_rdy = (cyc >= ready_at);
            n_vec++;
            if (IREADY !== exp_rdy) begin
                n_err++;
                $display("FAIL iready cyc %0d: got %b expected %b", cyc, IREADY, exp_rdy);
            end
            if (exp_rdy && (prog.size() > 0 || $urandom_range(0, 3) != 0)) begin
                if (prog.size() > 0)   beat = prog.pop_front();
                else if (pending_load) beat = 10'($urandom);
                else                   beat = rand_instr();
                INSTR  = beat;
                IVALID = 1'b1;
                model_accept(beat, cyc + 1);
                issued++;
            end else begin
                IVALID = exp_rdy ? 1'b0 : 1'($urandom);
                INSTR  = 10'($urandom);
            end
        end
        if (issued < n) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got %0d beats issued expected %0d", issued, n);
        end
    endtask

    // Monitor: every active cycle must match the oldest queued expectation.
    always @(posedge CLKb) begin
        rec_t r;
        if (ENW | ENR0 | ENR1 | LD_A | LD_G | DONE | ERR) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat cyc %0d: got %h expected no activity", cyc, act_vec);
            end else begin
                r = sb.pop_front();
                if (r.v !== act_vec || r.cyc != cyc) begin
                    n_err++;
                    $display("FAIL output_beat: got %h at cyc %0d expected %h at cyc %0d",
                             act_vec, cyc, r.v, r.cyc);
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            r = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_beat cyc %0d: got %h expected %h", cyc, act_vec, r.v);
        end
    end

    logic [27:0] rst_vec;

    initial begin
        rst_vec = mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0,
                     10'd0, 1'b0, 1'b0, 1'b1);
        RSTb   = 1'b0;
        IVALID = 1'b0;
        INSTR  = 10'd0;
        repeat (2) @(posedge CLKb);
        #1;
        n_vec++;
        if (act_vec !== rst_vec) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", act_vec, rst_vec);
        end
        RSTb     = 1'b1;
        ready_at = cyc;

        // LOAD R2 + imm, ADD R3,R1, COPY R0<=R2 then SUB R0,R0, illegal, COPY R2<=R1
        prog.push_back(10'h020);
        prog.push_back(10'h2AA);
        prog.push_back(10'h0B4);
        prog.push_back(10'h048);
        prog.push_back(10'h0C0);
        prog.push_back(10'h3C0);
        prog.push_back(10'h064);
        run_beats(7);
        run_beats(80);
        while (pending_load) run_beats(1);

        // XOR R1,R2 interrupted by reset during its EXEC cycle
        prog.push_back(10'h118);
        run_beats(1);
        @(posedge CLKb);
        IVALID = 1'b0;
        @(posedge CLKb);
        #1;
        RSTb = 1'b0;
        #1;
        n_vec++;
        if (act_vec !== rst_vec) begin
            n_err++;
            $display("FAIL reset_abort: got %h expected %h", act_vec, rst_vec);
        end
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        m_imm        = 10'd0;
        pending_load = 1'b0;
        repeat (2) @(negedge CLKb);
        @(posedge CLKb);
        #1;
        RSTb     = 1'b1;
        ready_at = cyc;

        prog.push_back(10'h048);
        run_beats(1);
        run_beats(120);
        while (pending_load) run_beats(1);

        @(posedge CLKb);
        IVALID = 1'b0;
        repeat (6) @(posedge CLKb);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: got %0d pending beats expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
